frame_fetch_scheduler: RTL and testbench



---
 rtl/frame_fetch_if.sv | 25 ++
 rtl/frame_fetch_scheduler.sv | 164 ++++++++++++++++
 tb/tb_frame_fetch_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_fetch_if.sv
// AXI4 read-address channel plus the per-burst completion strobe.
// Signal suffixes are named from the scheduler's point of view:
// _o is driven by the master and _i is driven by the slave side.
interface frame_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 2
);
    logic [ID_W-1:0]   m_arid_o;
    logic [ADDR_W-1:0] m_araddr_o;
    logic [7:0]        m_arlen_o;
    logic [1:0]        m_arburst_o;
    logic              m_arvalid_o;
    logic              m_arready_i;
    logic              r_done_i;

    modport master (
        output m_arid_o, m_araddr_o, m_arlen_o, m_arburst_o, m_arvalid_o,
        input  m_arready_i, r_done_i
    );

    modport slave (
        input  m_arid_o, m_araddr_o, m_arlen_o, m_arburst_o, m_arvalid_o,
        output m_arready_i, r_done_i
    );
endinterface

// File: rtl/frame_fetch_scheduler.sv
// Frame fetch scheduler: issues the AR bursts of one frame, tags each
// burst with a round-robin image-processor index on ARID, caps the number
// of bursts in flight and reports frame busy/done to frame-level control.
module frame_fetch_scheduler #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int IP_AMT    = 2,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 16,
    parameter int MAX_OUTS  = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  frame_bursts_i,
    output logic              busy_o,
    output logic              done_o,
    frame_fetch_if.master     ar_if
);

    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int OUT_W       = $clog2(MAX_OUTS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ID_W-1:0]    ip_idx_q, ip_idx_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               arvalid_q, arvalid_d;
    // Abort seen while a request was stalled; the stalled request must
    // still complete its handshake before the frame drains.
    logic               abort_pend_q, abort_pend_d;
    logic               ar_hs;

    assign ar_hs = arvalid_q & ar_if.m_arready_i;

    // In-flight burst count: +1 per AR handshake, -1 per returned burst,
    // unchanged when both happen together, never below zero.
    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !ar_if.r_done_i) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!ar_hs && ar_if.r_done_i && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    // Frame sequencing: next state, address/index/remaining updates and AR valid.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ip_idx_d     = ip_idx_q;
        remaining_d  = remaining_q;
        arvalid_d    = arvalid_q;
        abort_pend_d = abort_pend_q;

        if (ar_hs) begin
            addr_d      = addr_q + ADDR_W'(BURST_BYTES);
            ip_idx_d    = (ip_idx_q == ID_W'(IP_AMT - 1)) ? '0 : ip_idx_q + ID_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                arvalid_d    = 1'b0;
                abort_pend_d = 1'b0;
                if (start_i) begin
                    if (frame_bursts_i != '0) begin
                        addr_d      = base_addr_i;
                        remaining_d = frame_bursts_i;
                        ip_idx_d    = '0;
                        state_d     = S_ISSUE;
                    end else begin
                        // Empty frame: pass through DRAIN (nothing in flight)
                        // so busy shows for one cycle before the done pulse.
                        remaining_d = '0;
                        state_d     = S_DRAIN;
                    end
                end
            end

            S_ISSUE: begin
                if (arvalid_q) begin
                    if (ar_hs) begin
                        if (abort_i || abort_pend_q || (remaining_q == CNT_W'(1))) begin
                            arvalid_d = 1'b0;
                            state_d   = S_DRAIN;
                        end else begin
                            // Back-to-back issue when the window still has room.
                            arvalid_d = (outstanding_d < OUT_W'(MAX_OUTS));
                        end
                    end else if (abort_i) begin
                        // Request is committed on the bus; remember the abort.
                        abort_pend_d = 1'b1;
                    end
                end else if (abort_i) begin
                    state_d = S_DRAIN;
                end else begin
                    arvalid_d = (outstanding_q < OUT_W'(MAX_OUTS));
                end
            end

            S_DRAIN: begin
                arvalid_d    = 1'b0;
                abort_pend_d = 1'b0;
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                arvalid_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                arvalid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including a
    // pending AR request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            ip_idx_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            arvalid_q     <= 1'b0;
            abort_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ip_idx_q      <= ip_idx_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            arvalid_q     <= arvalid_d;
            abort_pend_q  <= abort_pend_d;
        end
    end

    assign busy_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o = (state_q == S_DONE);

    assign ar_if.m_arvalid_o = arvalid_q;
    assign ar_if.m_araddr_o  = addr_q;
    assign ar_if.m_arid_o    = ip_idx_q;
    assign ar_if.m_arlen_o   = 8'(BURST_LEN - 1);
    assign ar_if.m_arburst_o = 2'b01;

endmodule

// File: tb/tb_frame_fetch_scheduler.sv
// Testbench for frame_fetch_scheduler: directed scenarios followed by
// randomized frames, all checked against a burst-level reference model.
module tb_frame_fetch_scheduler;

    localparam int MAX_OUTS    = 4;
    localparam int IP_AMT      = 2;
    localparam int BURST_LEN   = 16;
    localparam int BURST_BYTES = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [31:0] base_addr_i;
    logic [15:0] frame_bursts_i;
    logic        busy_o;
    logic        done_o;

    frame_fetch_if #(.ADDR_W(32), .ID_W(2)) ar ();

    frame_fetch_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .base_addr_i    (base_addr_i),
        .frame_bursts_i (frame_bursts_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ar_if          (ar)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    // Reference model: the frame is a list of bursts numbered 0..frame_n-1;
    // burst k lives at base + k*BURST_BYTES with destination k % IP_AMT.
    logic [31:0] exp_base = '0;
    int          frame_n = 0;
    int          exp_cnt = 0;
    int          rdq[$];          // due cycle of each burst in flight
    int          rd_delay = 4;
    bit          rd_rand = 1'b0;
    bit          rd_en = 1'b1;
    int          rdy_mode = 1;    // 0: never ready, 1: always, 2: random
    int          abort_at = -1;
    int          last_rd_cyc = 0;
    int          done_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_delay();
        if (rd_rand) return int'($urandom_range(1, 8));
        return rd_delay;
    endfunction

    function automatic logic [31:0] burst_addr(input int k);
        return exp_base + 32'(k * BURST_BYTES);
    endfunction

    // Sets slave-side inputs for the coming clock edge.
    task automatic drive();
        case (rdy_mode)
            0:       ar.m_arready_i = 1'b0;
            1:       ar.m_arready_i = 1'b1;
            default: ar.m_arready_i = ($urandom_range(0, 99) < 60);
        endcase
        ar.r_done_i = 1'b0;
        if (rd_en && (rdq.size() > 0) && (rdq[0] <= cyc)) ar.r_done_i = 1'b1;
        abort_i = (cyc == abort_at);
    endtask

    // Advances one clock, updating the model from what was on the bus
    // before the edge and checking the outputs after it.
    task automatic tick();
        logic hs, rd, stall;
        hs    = ar.m_arvalid_o & ar.m_arready_i;
        rd    = ar.r_done_i;
        stall = ar.m_arvalid_o & ~ar.m_arready_i;
        if (hs) begin
            chk("ar_addr", 64'(ar.m_araddr_o), 64'(burst_addr(exp_cnt)));
            chk("ar_id", 64'(ar.m_arid_o), 64'(exp_cnt % IP_AMT));
            chk("ar_len", 64'(ar.m_arlen_o), 64'(BURST_LEN - 1));
            chk("ar_burst", 64'(ar.m_arburst_o), 64'(1));
            chk("ar_in_frame", 64'(exp_cnt < frame_n), 64'(1));
            exp_cnt++;
            rdq.push_back(cyc + pick_delay());
        end
        if (rd) begin
            if (rdq.size() > 0) void'(rdq.pop_front());
            last_rd_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall) begin
            chk("ar_hold_valid", 64'(ar.m_arvalid_o), 64'(1));
            chk("ar_hold_addr", 64'(ar.m_araddr_o), 64'(burst_addr(exp_cnt)));
            chk("ar_hold_id", 64'(ar.m_arid_o), 64'(exp_cnt % IP_AMT));
        end
        chk("inflight_cap", 64'(rdq.size() <= MAX_OUTS), 64'(1));
        if (ar.m_arvalid_o) chk("valid_implies_busy", 64'(busy_o), 64'(1));
        if (done_o) done_cyc = cyc;
    endtask

    task automatic start_frame(input logic [31:0] base, input int n);
        base_addr_i    = base;
        frame_bursts_i = 16'(n);
        start_i        = 1'b1;
        exp_base       = base;
        frame_n        = n;
        exp_cnt        = 0;
        drive();
        tick();
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(1));
    endtask

    task automatic run_to_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            drive();
            tick();
            if (done_o) break;
        end
        chk("done_reached", 64'(done_o), 64'(1));
        chk("drained_at_done", 64'(rdq.size()), 64'(0));
        chk("busy_low_at_done", 64'(busy_o), 64'(0));
        abort_at = -1;
        drive();
        tick();
        chk("done_single_pulse", 64'(done_o), 64'(0));
        chk("idle_not_busy", 64'(busy_o), 64'(0));
        chk("idle_no_valid", 64'(ar.m_arvalid_o), 64'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        start_i        = 1'b0;
        abort_i        = 1'b0;
        base_addr_i    = '0;
        frame_bursts_i = '0;
        ar.m_arready_i = 1'b0;
        ar.r_done_i    = 1'b0;

        // Reset values
        #3;
        chk("rst_arvalid", 64'(ar.m_arvalid_o), 64'(0));
        chk("rst_araddr", 64'(ar.m_araddr_o), 64'(0));
        chk("rst_arid", 64'(ar.m_arid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_arlen", 64'(ar.m_arlen_o), 64'(15));
        chk("rst_arburst", 64'(ar.m_arburst_o), 64'(1));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Three bursts, always ready, each burst returns 4 cycles after AR
        rdy_mode = 1; rd_en = 1'b1; rd_rand = 1'b0; rd_delay = 4;
        start_frame(32'h0000_1000, 3);
        run_to_done(200);
        chk("t1_count", 64'(exp_cnt), 64'(3));
        chk("t1_done_latency", 64'(done_cyc), 64'(last_rd_cyc + 2));

        // Eight bursts with returns withheld: window fills at MAX_OUTS
        rd_en = 1'b0;
        start_frame(32'h0002_0000, 8);
        for (int k = 0; k < 20; k++) begin drive(); tick(); end
        chk("t2_window_full", 64'(exp_cnt), 64'(MAX_OUTS));
        chk("t2_valid_low", 64'(ar.m_arvalid_o), 64'(0));
        for (int r = 0; r < 4; r++) begin
            ar.m_arready_i = 1'b1;
            ar.r_done_i = 1'b1;
            tick();
            ar.r_done_i = 1'b0;
            tick(); tick(); tick();
            chk("t2_release_one", 64'(exp_cnt), 64'(MAX_OUTS + 1 + r));
        end
        rd_en = 1'b1;
        run_to_done(200);
        chk("t2_count", 64'(exp_cnt), 64'(8));

        // Stall with abort in the middle: stalled request completes, rest dropped
        rdy_mode = 0;
        start_frame(32'h0004_0000, 6);
        for (int k = 0; k < 10 && !ar.m_arvalid_o; k++) begin drive(); tick(); end
        chk("t3_valid_up", 64'(ar.m_arvalid_o), 64'(1));
        abort_at = cyc + 2;
        for (int s = 0; s < 5; s++) begin drive(); tick(); end
        rdy_mode = 1;
        drive();
        tick();
        chk("t3_one_issued", 64'(exp_cnt), 64'(1));
        for (int k = 0; k < 2; k++) begin drive(); tick(); end
        chk("t3_no_more_valid", 64'(ar.m_arvalid_o), 64'(0));
        run_to_done(200);
        chk("t3_count", 64'(exp_cnt), 64'(1));

        // Handshake and burst return in the same cycle with the window nearly full
        rd_en = 1'b0; rdy_mode = 1;
        start_frame(32'h0006_0000, 8);
        for (int k = 0; k < 40 && !(exp_cnt == 3 && ar.m_arvalid_o); k++) begin
            drive(); tick();
        end
        chk("t4_setup", 64'(exp_cnt), 64'(3));
        ar.m_arready_i = 1'b1;
        ar.r_done_i = 1'b1;
        tick();
        ar.r_done_i = 1'b0;
        chk("t4_issued", 64'(exp_cnt), 64'(4));
        chk("t4_inflight_same", 64'(rdq.size()), 64'(3));
        chk("t4_valid_stays", 64'(ar.m_arvalid_o), 64'(1));
        rd_en = 1'b1;
        run_to_done(200);
        chk("t4_count", 64'(exp_cnt), 64'(8));

        // Empty frame, then start pulses during a busy frame are ignored
        start_frame(32'h0008_0000, 0);
        chk("t5_no_valid", 64'(ar.m_arvalid_o), 64'(0));
        drive();
        tick();
        chk("t5_done", 64'(done_o), 64'(1));
        chk("t5_busy_low", 64'(busy_o), 64'(0));
        chk("t5_no_valid2", 64'(ar.m_arvalid_o), 64'(0));
        drive();
        tick();
        chk("t5_done_gone", 64'(done_o), 64'(0));
        start_frame(32'h000A_0000, 4);
        drive(); tick();
        base_addr_i = 32'h0F00_0000;
        frame_bursts_i = 16'd1;
        start_i = 1'b1;
        drive(); tick();
        start_i = 1'b0;
        run_to_done(200);
        chk("t5_count", 64'(exp_cnt), 64'(4));

        // Asynchronous reset mid-frame with two bursts in flight
        rd_en = 1'b0;
        start_frame(32'h000C_0000, 8);
        for (int k = 0; k < 20 && exp_cnt < 2; k++) begin drive(); tick(); end
        chk("t6_setup", 64'(exp_cnt), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(ar.m_arvalid_o), 64'(0));
        chk("t6_rst_addr", 64'(ar.m_araddr_o), 64'(0));
        chk("t6_rst_id", 64'(ar.m_arid_o), 64'(0));
        chk("t6_rst_busy", 64'(busy_o), 64'(0));
        chk("t6_rst_done", 64'(done_o), 64'(0));
        rdq.delete();
        exp_cnt = 0;
        frame_n = 0;
        ar.m_arready_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd_en = 1'b1;
        start_frame(32'h0010_0000, 3);
        run_to_done(200);
        chk("t6_count", 64'(exp_cnt), 64'(3));

        // Randomized frames: random ready, return delays, sizes, bases, aborts
        rdy_mode = 2; rd_rand = 1'b1;
        for (int f = 0; f < 12; f++) begin
            logic [31:0] b;
            int n;
            bit ab;
            b  = $urandom() & 32'hFFFF_FE00;
            n  = int'($urandom_range(1, 10));
            if (f % 4 == 3) begin b = 32'hFFFF_FC00; n = 5; end
            ab = ($urandom_range(0, 3) == 0);
            start_frame(b, n);
            abort_at = ab ? cyc + int'($urandom_range(1, 10)) : -1;
            run_to_done(600);
            if (!ab) chk("rand_count", 64'(exp_cnt), 64'(n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
